// File: rtl/fp_align_stage.sv
// fp_align_stage: two-stage pre-add alignment for the FP adder/subtractor.
//   Stage 1 compares magnitudes, swaps operands and forms the exponent difference.
//   Stage 2 right-shifts the smaller fraction by that difference.
// i_mode=1 handles one double; i_mode=0 handles two packed singles
// (lane H = [63:32], lane L = [31:0]) that never exchange bits.
// Optional feature: define FP_ALIGN_STICKY_EN to add o_sticky[1:0], the OR of
// the bits shifted out of the small fraction per lane. Without it those bits
// are truncated.

module fp_align_stage #(
    parameter int STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_mode,
    input  logic        i_sub,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_mode,
    output logic [1:0]  e_op,
    output logic [1:0]  o_sign,
    output logic [15:0] e_large_exp,
    output logic [53:0] a_aligned_large_frac54,
    output logic [53:0] a_aligned_small_frac54
`ifdef FP_ALIGN_STICKY_EN
    ,
    output logic [1:0]  o_sticky
`endif
);

    if (STAGES != 2) begin : g_stages_check
        $error("fp_align_stage: only STAGES=2 is supported");
    end

    // Result of comparing/swapping one single-precision lane.
    typedef struct packed {
        logic        sign;
        logic        op;
        logic [7:0]  exp_out;
        logic [23:0] sig_large;
        logic [23:0] sig_small;
        logic [5:0]  shift;
    } lane_s_t;

    // Payload held between stage 1 and stage 2.
    typedef struct packed {
        logic        mode;
        logic [1:0]  op;
        logic [1:0]  sign;
        logic [15:0] large_exp;
        logic [53:0] large_frac;
        logic [53:0] small_frac;   // not yet shifted
        logic [5:0]  shift_h;      // double shift, or lane H shift
        logic [5:0]  shift_l;      // lane L shift (single only)
    } s1_t;

    // Compare/swap one single lane. {exp,frac} of a positive float orders like
    // an unsigned integer, so the magnitude compare is a plain 31-bit compare.
    function automatic lane_s_t align_single(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sub);
        lane_s_t     r;
        logic        a_large;
        logic [7:0]  exp_l, exp_s, eff_l, eff_s, diff;
        logic [22:0] frac_l, frac_s;
        a_large     = (a[30:0] >= b[30:0]);
        exp_l       = a_large ? a[30:23] : b[30:23];
        exp_s       = a_large ? b[30:23] : a[30:23];
        frac_l      = a_large ? a[22:0]  : b[22:0];
        frac_s      = a_large ? b[22:0]  : a[22:0];
        // Subnormals share the scale of exponent 1.
        eff_l       = (exp_l == 8'd0) ? 8'd1 : exp_l;
        eff_s       = (exp_s == 8'd0) ? 8'd1 : exp_s;
        diff        = eff_l - eff_s;
        r.sign      = a_large ? a[31] : (b[31] ^ sub);
        r.op        = sub ^ a[31] ^ b[31];
        r.exp_out   = (exp_l != 8'd0) ? exp_l : {7'd0, (frac_l != 23'd0)};
        r.sig_large = {(exp_l != 8'd0), frac_l};
        r.sig_small = {(exp_s != 8'd0), frac_s};
        // Any shift of 24 or more already clears a 24-bit significand.
        r.shift     = (diff > 8'd31) ? 6'd31 : diff[5:0];
        return r;
    endfunction

    logic        s1_valid;
    logic        s1_advance;
    logic        accept;
    s1_t         s1_nxt;
    s1_t         s1_q;

    lane_s_t     lane_h, lane_l;
    logic        d_a_large;
    logic [10:0] d_exp_l, d_exp_s, d_eff_l, d_eff_s, d_diff;
    logic [51:0] d_frac_l, d_frac_s;
    logic        d_op, d_sign;
    logic [10:0] d_exp_out;

    logic [23:0] sig_h_sh, sig_l_sh;
    logic [53:0] small_nxt;

    // Handshake: the output stage empties when consumed, stage 1 moves forward
    // whenever the output stage is empty or emptying.
    assign s1_advance = s1_valid && (!o_valid || i_ready);
    assign o_ready    = !s1_valid || s1_advance;
    assign accept     = i_valid && o_ready;

    // Stage 1 combinational: compare, swap and exponent difference for both formats.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        s1_nxt    = '0;
        lane_h    = align_single(i_a[63:32], i_b[63:32], i_sub);
        lane_l    = align_single(i_a[31:0],  i_b[31:0],  i_sub);

        d_a_large = (i_a[62:0] >= i_b[62:0]);
        d_exp_l   = d_a_large ? i_a[62:52] : i_b[62:52];
        d_exp_s   = d_a_large ? i_b[62:52] : i_a[62:52];
        d_frac_l  = d_a_large ? i_a[51:0]  : i_b[51:0];
        d_frac_s  = d_a_large ? i_b[51:0]  : i_a[51:0];
        d_eff_l   = (d_exp_l == 11'd0) ? 11'd1 : d_exp_l;
        d_eff_s   = (d_exp_s == 11'd0) ? 11'd1 : d_exp_s;
        d_diff    = d_eff_l - d_eff_s;
        d_op      = i_sub ^ i_a[63] ^ i_b[63];
        d_sign    = d_a_large ? i_a[63] : (i_b[63] ^ i_sub);
        d_exp_out = (d_exp_l != 11'd0) ? d_exp_l : {10'd0, (d_frac_l != 52'd0)};

        s1_nxt.mode = i_mode;
        if (i_mode) begin
            s1_nxt.op         = {2{d_op}};
            s1_nxt.sign       = {2{d_sign}};
            s1_nxt.large_exp  = {5'd0, d_exp_out};
            s1_nxt.large_frac = {1'b0, (d_exp_l != 11'd0), d_frac_l};
            s1_nxt.small_frac = {1'b0, (d_exp_s != 11'd0), d_frac_s};
            // Saturate at 63: anything from 54 up clears the 54-bit fraction.
            s1_nxt.shift_h    = (d_diff > 11'd63) ? 6'd63 : d_diff[5:0];
            s1_nxt.shift_l    = 6'd0;
        end else begin
            s1_nxt.op         = {lane_h.op, lane_l.op};
            s1_nxt.sign       = {lane_h.sign, lane_l.sign};
            s1_nxt.large_exp  = {lane_h.exp_out, lane_l.exp_out};
            s1_nxt.large_frac = {1'b0, lane_h.sig_large, 5'd0, lane_l.sig_large};
            s1_nxt.small_frac = {1'b0, lane_h.sig_small, 5'd0, lane_l.sig_small};
            s1_nxt.shift_h    = lane_h.shift;
            s1_nxt.shift_l    = lane_l.shift;
        end
    end

    // Stage 1 register: capture on accept, empty when the payload moves on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            // NOTE: datapath registers are reset too, so the pipe is deterministic after any reset.
            s1_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                s1_valid <= 1'b1;
                s1_q     <= s1_nxt;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 combinational: shift the small fraction; single lanes shift separately.
    always_comb begin
        sig_h_sh  = s1_q.small_frac[52:29] >> s1_q.shift_h;
        sig_l_sh  = s1_q.small_frac[23:0]  >> s1_q.shift_l;
        small_nxt = s1_q.mode ? (s1_q.small_frac >> s1_q.shift_h)
                              : {1'b0, sig_h_sh, 5'd0, sig_l_sh};
    end

    // Output register: load from stage 1 when it advances, otherwise hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid                <= 1'b0;
            o_mode                 <= 1'b0;
            e_op                   <= 2'b00;
            o_sign                 <= 2'b00;
            e_large_exp            <= 16'd0;
            a_aligned_large_frac54 <= 54'd0;
            a_aligned_small_frac54 <= 54'd0;
        end else begin
            if (s1_advance) begin
                o_valid                <= 1'b1;
                o_mode                 <= s1_q.mode;
                e_op                   <= s1_q.op;
                o_sign                 <= s1_q.sign;
                e_large_exp            <= s1_q.large_exp;
                a_aligned_large_frac54 <= s1_q.large_frac;
                a_aligned_small_frac54 <= small_nxt;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef FP_ALIGN_STICKY_EN
    logic [1:0] sticky_nxt;

    // Sticky: a bit was lost iff shifting the result back does not restore the input.
    always_comb begin
        sticky_nxt = 2'b00;
        if (s1_q.mode) begin
            sticky_nxt = {2{(small_nxt << s1_q.shift_h) != s1_q.small_frac}};
        end else begin
            sticky_nxt[1] = (sig_h_sh << s1_q.shift_h) != s1_q.small_frac[52:29];
            sticky_nxt[0] = (sig_l_sh << s1_q.shift_l) != s1_q.small_frac[23:0];
        end
    end

    // Sticky register, loaded alongside the other outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sticky <= 2'b00;
        end else if (s1_advance) begin
            o_sticky <= sticky_nxt;
        end
    end
`endif

endmodule
